// File: rtl/quadrant_frame_scheduler.sv
// Frame-synchronous datagram scheduler: shadow-buffers core writes and commits them to each
// quadrant's active datagram only at that quadrant's frame start, so no frame tears mid-scan.
module quadrant_frame_scheduler #(
  parameter int MSG_W     = 32,
  parameter int NQ        = 4,
  parameter int HOLD_MODE = 0,
  parameter int OVR_W     = 8,
  parameter int FRAME_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [MSG_W-1:0]    in_data,
  output logic                in_ready,
  input  logic [NQ-1:0]       vsync,
  output logic [NQ*MSG_W-1:0] datagram_out,
  output logic [NQ-1:0]       commit_pulse,
  output logic [NQ-1:0]       pending,
  output logic                all_synced,
  output logic [OVR_W-1:0]    overrun_cnt,
  output logic [FRAME_W-1:0]  frame_cnt
);

  typedef enum logic {
    SYNCED = 1'b0,
    WAIT   = 1'b1
  } q_state_e;

  q_state_e          state_q [NQ];
  q_state_e          state_d [NQ];
  logic [NQ-1:0]     vs_sync1, vs_sync2, vs_prev;
  logic [NQ-1:0]     fs, commit, pending_next;
  logic [MSG_W-1:0]  shadow;
  logic              wr;

  assign wr = in_valid & in_ready;
  assign fs = vs_prev & ~vs_sync2;

  // NOTE: synchronizer flops preset to 1 so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_sync1 <= '1;
      vs_sync2 <= '1;
      vs_prev  <= '1;
    end else begin
      vs_sync1 <= vsync;
      vs_sync2 <= vs_sync1;
      vs_prev  <= vs_sync2;
    end
  end

  // Per-quadrant SYNCED/WAIT machine; a write always wins over a frame start.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    pending      = '0;
    pending_next = '0;
    commit       = '0;
    for (int q = 0; q < NQ; q++) begin
      state_d[q] = state_q[q];
      case (state_q[q])
        SYNCED:  if (wr) state_d[q] = WAIT;
        WAIT:    if (!wr && fs[q]) state_d[q] = SYNCED;
        default: state_d[q] = SYNCED;
      endcase
      pending[q]      = (state_q[q] == WAIT);
      pending_next[q] = (state_d[q] == WAIT);
      commit[q]       = fs[q] & pending[q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < NQ; q++) state_q[q] <= SYNCED;
    end else begin
      for (int q = 0; q < NQ; q++) state_q[q] <= state_d[q];
    end
  end

  // Reset clears the active datagrams too: the output interfaces then render state 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow       <= '0;
      datagram_out <= '0;
      commit_pulse <= '0;
      overrun_cnt  <= '0;
      frame_cnt    <= '0;
      in_ready     <= 1'b0;
      all_synced   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here mean a commit copies the shadow value from before
      // any write landing on the same edge.
      commit_pulse <= commit;
      for (int q = 0; q < NQ; q++) begin
        if (commit[q]) datagram_out[q*MSG_W +: MSG_W] <= shadow;
      end
      if (wr) begin
        shadow <= in_data;
        if ((|pending) && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + 1'b1;
      end
      if (fs[0]) frame_cnt <= frame_cnt + 1'b1;
      if (HOLD_MODE != 0) in_ready <= (pending_next == '0);
      else                in_ready <= 1'b1;
      all_synced <= (pending_next == '0);
    end
  end

endmodule

// File: tb/tb_quadrant_frame_scheduler.sv
// Bench for quadrant_frame_scheduler: an overwrite-mode instance (a) and a hold-mode instance (b)
// with a 4-bit frame counter, both checked every cycle against a cycle-level behavioural model.
module tb_quadrant_frame_scheduler;

  localparam int MSG_W = 32;
  localparam int NQ    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              valid_a, valid_b;
  logic [MSG_W-1:0]  data_a, data_b;
  logic              ready_a, ready_b;
  logic [NQ-1:0]     vs_a, vs_b;
  logic [127:0]      dout_a, dout_b;
  logic [NQ-1:0]     pulse_a, pulse_b, pend_a, pend_b;
  logic              synced_a, synced_b;
  logic [7:0]        ovr_a, ovr_b;
  logic [15:0]       frm_a;
  logic [3:0]        frm_b;

  quadrant_frame_scheduler #(.MSG_W(MSG_W), .NQ(NQ), .HOLD_MODE(0), .OVR_W(8), .FRAME_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
    .vsync(vs_a), .datagram_out(dout_a), .commit_pulse(pulse_a), .pending(pend_a),
    .all_synced(synced_a), .overrun_cnt(ovr_a), .frame_cnt(frm_a));

  quadrant_frame_scheduler #(.MSG_W(MSG_W), .NQ(NQ), .HOLD_MODE(1), .OVR_W(8), .FRAME_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
    .vsync(vs_b), .datagram_out(dout_b), .commit_pulse(pulse_b), .pending(pend_b),
    .all_synced(synced_b), .overrun_cnt(ovr_b), .frame_cnt(frm_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame start takes effect on the edge three clocks after the raw low sample, i.e. when the
  // raw value seen two edges ago is 0 and the one seen three edges ago is 1.
  logic [MSG_W-1:0] m_shadow [2];
  logic [MSG_W-1:0] m_act    [2][NQ];
  logic [NQ-1:0]    m_pend [2], m_pulse [2];
  logic [NQ-1:0]    h1 [2], h2 [2], h3 [2];
  int               m_ovr [2], m_frm [2];
  logic             m_rdy [2], m_synced [2];

  task automatic model_reset(input int i);
    m_shadow[i] = '0;
    for (int q = 0; q < NQ; q++) m_act[i][q] = '0;
    m_pend[i] = '0; m_pulse[i] = '0;
    h1[i] = '1; h2[i] = '1; h3[i] = '1;
    m_ovr[i] = 0; m_frm[i] = 0;
    m_rdy[i] = 1'b0; m_synced[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input logic v, input logic [MSG_W-1:0] d,
                            input logic [NQ-1:0] raw);
    logic [NQ-1:0] fs;
    logic          wr;
    fs = h3[i] & ~h2[i];
    h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = raw;
    wr = v & m_rdy[i];
    for (int q = 0; q < NQ; q++) begin
      m_pulse[i][q] = fs[q] & m_pend[i][q];
      if (m_pulse[i][q]) m_act[i][q] = m_shadow[i];
    end
    if (fs[0]) m_frm[i] = (m_frm[i] + 1) % ((i == 0) ? 65536 : 16);
    if (wr) begin
      if (m_pend[i] != 0 && m_ovr[i] < 255) m_ovr[i]++;
      m_shadow[i] = d;
      m_pend[i]   = '1;
    end else begin
      m_pend[i] = m_pend[i] & ~fs;
    end
    m_rdy[i]    = (i == 1) ? (m_pend[i] == 0) : 1'b1;
    m_synced[i] = (m_pend[i] == 0);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, valid_a, data_a, vs_a);
      model_step(1, valid_b, data_b, vs_b);
    end
  end

  task automatic compare_all();
    logic [127:0] ea, eb;
    for (int q = 0; q < NQ; q++) begin
      ea[q*MSG_W +: MSG_W] = m_act[0][q];
      eb[q*MSG_W +: MSG_W] = m_act[1][q];
    end
    check("a.in_ready",     128'(ready_a),  128'(m_rdy[0]));
    check("a.datagram_out", dout_a,         ea);
    check("a.commit_pulse", 128'(pulse_a),  128'(m_pulse[0]));
    check("a.pending",      128'(pend_a),   128'(m_pend[0]));
    check("a.all_synced",   128'(synced_a), 128'(m_synced[0]));
    check("a.overrun_cnt",  128'(ovr_a),    128'(m_ovr[0]));
    check("a.frame_cnt",    128'(frm_a),    128'(m_frm[0]));
    check("b.in_ready",     128'(ready_b),  128'(m_rdy[1]));
    check("b.datagram_out", dout_b,         eb);
    check("b.commit_pulse", 128'(pulse_b),  128'(m_pulse[1]));
    check("b.pending",      128'(pend_b),   128'(m_pend[1]));
    check("b.all_synced",   128'(synced_b), 128'(m_synced[1]));
    check("b.overrun_cnt",  128'(ovr_b),    128'(m_ovr[1]));
    check("b.frame_cnt",    128'(frm_b),    128'(m_frm[1]));
  endtask

  always @(negedge clk) compare_all();

  // ---------------- stimulus helpers ----------------
  function automatic logic [NQ-1:0] get_pulse(input int i);
    return (i == 0) ? pulse_a : pulse_b;
  endfunction

  function automatic logic [MSG_W-1:0] get_slice(input int i, input int q);
    logic [127:0] d;
    d = (i == 0) ? dout_a : dout_b;
    return d[q*MSG_W +: MSG_W];
  endfunction

  task automatic set_vs(input int i, input int q, input logic v);
    if (i == 0) vs_a[q] = v;
    else        vs_b[q] = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle low pulse on vsync[q]; the commit must appear on the third edge and last one cycle.
  task automatic pulse_vs(input int i, input int q, input logic exp_commit,
                          input logic [MSG_W-1:0] exp_data);
    logic [NQ-1:0] exp_p;
    exp_p = exp_commit ? (NQ'(1) << q) : '0;
    @(negedge clk); set_vs(i, q, 1'b0);
    @(negedge clk); set_vs(i, q, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check($sformatf("pulse[%0d][%0d] on 3rd edge", i, q), 128'(get_pulse(i)), 128'(exp_p));
    if (exp_commit)
      check($sformatf("slice[%0d][%0d] loaded", i, q), 128'(get_slice(i, q)), 128'(exp_data));
    @(negedge clk);
    check($sformatf("pulse[%0d][%0d] one cycle", i, q), 128'(get_pulse(i)), 128'(0));
  endtask

  task automatic write_a(input logic [MSG_W-1:0] d);
    @(negedge clk); valid_a = 1'b1; data_a = d;
    @(negedge clk); valid_a = 1'b0;
  endtask

  localparam logic [MSG_W-1:0] DA5 = 32'hA5A5_A5A5;
  localparam logic [MSG_W-1:0] D1  = 32'h1111_0001;
  localparam logic [MSG_W-1:0] D2  = 32'h2222_0002;

  initial begin
    valid_a = 1'b0; valid_b = 1'b0;
    data_a  = '0;   data_b  = '0;
    vs_a    = '1;   vs_b    = '1;
    #1 rst = 1'b0;

    // Reset and release; a frame start with nothing pending changes nothing.
    cyc(3);
    check("reset in_ready", 128'(ready_a), 128'(0));
    check("reset datagram_out", dout_a, 128'(0));
    rst = 1'b1;
    @(negedge clk);
    check("in_ready after release", 128'(ready_a), 128'(1));
    pulse_vs(0, 2, 1'b0, '0);
    check("no frame count on q2", 128'(frm_a), 128'(0));
    check("datagram_out unchanged", dout_a, 128'(0));

    // Single write, staggered commits.
    write_a(DA5);
    check("pending after write", 128'(pend_a), 128'(4'hF));
    for (int q = 0; q < NQ; q++) begin
      cyc(q + 1);
      pulse_vs(0, q, 1'b1, DA5);
    end
    check("all_synced after commits", 128'(synced_a), 128'(1));
    check("no overrun", 128'(ovr_a), 128'(0));
    check("frame_cnt one", 128'(frm_a), 128'(1));

    // Overwrite before full commit: D1 is skipped by quadrants 1-3.
    write_a(D1);
    pulse_vs(0, 0, 1'b1, D1);
    write_a(D2);
    check("overrun once", 128'(ovr_a), 128'(1));
    check("pending refilled", 128'(pend_a), 128'(4'hF));
    for (int q = 0; q < NQ; q++) pulse_vs(0, q, 1'b1, D2);
    check("all quadrants on D2", dout_a, {4{D2}});

    // Write landing on the same edge as fs[1]: quadrant 1 takes the old shadow, stays pending.
    write_a(D1);
    @(negedge clk); set_vs(0, 1, 1'b0);
    @(negedge clk); set_vs(0, 1, 1'b1);
    @(negedge clk); valid_a = 1'b1; data_a = D2;
    @(negedge clk); valid_a = 1'b0;
    check("coincident commit old", 128'(get_slice(0, 1)), 128'(D1));
    check("coincident pulse", 128'(pulse_a), 128'(4'b0010));
    check("coincident pending", 128'(pend_a), 128'(4'hF));
    pulse_vs(0, 1, 1'b1, D2);
    for (int q = 0; q < NQ; q++) if (q != 1) pulse_vs(0, q, 1'b1, D2);

    // Hold mode: D2 waits until every quadrant has committed D1.
    @(negedge clk); valid_b = 1'b1; data_b = D1;
    @(negedge clk); data_b = D2;
    check("hold ready drops", 128'(ready_b), 128'(0));
    for (int q = 0; q < NQ; q++) begin
      if (q == NQ - 1) check("hold ready still low", 128'(ready_b), 128'(0));
      pulse_vs(1, q, 1'b1, D1);
    end
    valid_b = 1'b0;
    check("hold all D1", dout_b, {4{D1}});
    check("hold D2 accepted", 128'(pend_b), 128'(4'hF));
    check("hold no overrun", 128'(ovr_b), 128'(0));

    // 4-bit frame counter wraps after 16 more frame starts.
    pulse_vs(1, 0, 1'b1, D2);
    repeat (15) pulse_vs(1, 0, 1'b0, '0);
    check("frame_cnt wrapped", 128'(frm_b), 128'(1));

    // Randomised traffic on both instances; the per-cycle compare does the checking.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      valid_a = 1'($urandom_range(0, 3) == 0);
      data_a  = $urandom;
      vs_a    = NQ'($urandom);
      valid_b = 1'($urandom_range(0, 1));
      data_b  = $urandom;
      vs_b    = NQ'($urandom);
    end
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0; vs_a = '1; vs_b = '1;
    cyc(5);

    // 300 back-to-back writes with no frame starts: overrun saturates.
    @(negedge clk); valid_a = 1'b1;
    repeat (300) begin
      @(negedge clk); data_a = $urandom;
    end
    valid_a = 1'b0;
    @(negedge clk);
    check("overrun saturated", 128'(ovr_a), 128'(255));

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async reset datagram_out", dout_a, 128'(0));
    check("async reset overrun", 128'(ovr_a), 128'(0));
    check("async reset pending", 128'(pend_a), 128'(0));
    check("async reset in_ready", 128'(ready_a), 128'(0));
    check("async reset frame_cnt", 128'(frm_b), 128'(0));
    compare_all();
    #20 rst = 1'b1;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
